mux_n_1_stream_rr: RTL
======================

Name: mux_n_1_stream_rr

Overview:
- Parametrised N-to-1 streaming multiplexer with valid/ready handshake on every channel.
- Replaces fixed-select muxes where several producers share one consumer.
- A combinational arbiter picks one requesting input per cycle, in round-robin or fixed-priority mode.
- One output register stage carries the data and the index of the source channel.

Parameters:
- N, 4: number of input channels; legal range 2..16; need not be a power of two.
- W, 4: data width per channel.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- SEL_W, $clog2(N): width of the channel index. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  N  request per channel; bit i belongs to channel i.
- in_ready  output  N  accept per channel; combinational; at most one bit high.
- in_data  input  N*W  channel i data at bits [i*W +: W].
- out_valid  output  1  registered; output holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  W  registered data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - While rst is high, in_ready is forced to all zeros.
- Load condition: load = !out_valid || out_ready.
- Arbitration (combinational):
  - RR=1: search in_valid starting at index ptr, upward, wrapping from N-1 to 0. The first set bit is grant g.
  - RR=0: g = lowest set index of in_valid; ptr is ignored and stays at 0.
  - No valid inputs: no grant.
- Handshake:
  - in_ready[g] = load; all other in_ready bits are 0.
  - A transfer on channel g happens when in_valid[g] && in_ready[g].
  - in_ready never depends on in_valid of a non-granted channel.
- On a transfer: out_data <= in_data[g], out_sel <= g, out_valid <= 1. If RR=1, ptr <= (g==N-1) ? 0 : g+1.
- Output fires (out_valid && out_ready) with no transfer in the same cycle: out_valid <= 0. out_data and out_sel keep their values.
- Fire and transfer in the same cycle: the new word replaces the old one; out_valid stays 1. Full throughput is one word per cycle.
- Stall (out_valid && !out_ready):
  - out_data and out_sel hold stable.
  - All in_ready bits are 0; ptr holds.
- Latency: input transfer to out_valid is exactly 1 cycle.
- Producers may drop in_valid without a transfer; the arbiter simply re-evaluates.
- ptr advances only on a transfer, never on idle cycles.
- Data is passed through unmodified, including X/Z bits. No arithmetic is applied to the data.
- Reset mid-operation: any buffered word is discarded, with out_valid=0 on the next cycle. Pending inputs are not accepted in the reset cycle.
- Non-power-of-two N: ptr and grant never take values >= N.

Test Plan:
- Single-channel select: N=4, W=4, out_ready=1, in_data={d,c,b,a} (ch3..ch0), only in_valid[2]=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=c, out_sel=2.
- Round-robin fairness: all in_valid=1, out_ready=1 for 8 cycles after reset → out_sel sequence 0,1,2,3,0,1,2,3; out_data follows a,b,c,d,...
- Fixed priority: RR=0, in_valid=4'b1010 held → out_sel is always 1. Dropping in_valid[1] gives out_sel=3 on the next transfer.
- Backpressure: word a held with out_ready=0 for 3 cycles → out_data=a and out_sel=0 stable; in_ready=0; ptr unchanged. Raising out_ready gives fire plus the next transfer in the same cycle, with no bubble.
- Reset mid-stream: rst=1 while out_valid=1 → next cycle out_valid=0, out_data=0, out_sel=0. After release with all in_valid=1, the first grant is channel 0.
- X pass-through and wrap: N=3, in_data={x,10,7} (ch2..ch0), all in_valid=1 → words 7, 10, x, then 7. out_data equals 'x exactly under a !== check; out_sel wraps 2→0.

Source files
------------

// File: rtl/mux_n_1_stream_rr.sv
// N-to-1 valid/ready stream multiplexer with a combinational round-robin or
// fixed-priority arbiter and a single registered output stage carrying the source index.
module mux_n_1_stream_rr #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int RR = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel
);

  localparam int unsigned NU = N;
  localparam int unsigned WU = W;

  logic             valid_q;
  logic [W-1:0]     data_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] gnt;
  logic [W-1:0]     gnt_data;
  logic             gnt_vld;
  logic             load;
  logic             xfer;
  int unsigned      idx;

  assign load = !valid_q || out_ready;
  assign xfer = !rst && gnt_vld && load;

  // Search starts at ptr and wraps at N, so neither idx nor gnt can reach N.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = k + ((RR != 0) ? 32'(ptr_q) : 32'd0);
      if (idx >= NU) idx = idx - NU;
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld  = 1'b1;
        gnt      = SEL_W'(idx);
        gnt_data = in_data[idx*WU +: W];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      in_ready[i] = xfer && (gnt == SEL_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR != 0 && xfer) begin
      ptr_d = (gnt == SEL_W'(N - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= gnt_data;
        sel_q   <= gnt;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
